fft_stage_ctrl: RTL

FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

---
 rtl/fft_pkg.sv | 20 ++
 rtl/fft_stage_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for FFT stage controllers: state encoding and
// a constant log2 helper for sizing counters from frame parameters.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_stage_ctrl.sv
// Control for one radix-2 SDF FFT stage: butterfly/twiddle/valid timing.
// Optional input-gap checking under FFT_STAGE_CTRL_GAP_CHECK_EN.
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int N     = 64,
  parameter int DEPTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 di_en,
  output logic                 bf_en,
  output logic                 tw_en,
  output logic [$clog2(N)-1:0] tw_addr,
  output logic                 do_en,
  output logic                 frame_done,
  output logic                 err
);

  localparam int LN = log2(N);
  localparam int LD = log2(DEPTH);
  localparam int FW = (LD > 0) ? LD : 1;
  localparam int SH = LN - 1 - LD;

  state_e          state_q;
  logic [LN-1:0]   in_cnt_q;
  logic [LN-1:0]   out_cnt_q;
  logic [FW-1:0]   fl_cnt_q;
  logic            fl_act_q;
  logic            run_out;
  logic            fl_last;
  logic            in_last;

  assign in_last = in_cnt_q == LN'(N - 1);
  assign fl_last = fl_cnt_q == FW'(DEPTH - 1);

  // Flush outputs run on their own, so they may overlap the next frame's fill.
  assign run_out    = (state_q == RUN) & di_en
                    & (in_cnt_q >= LN'(DEPTH));
  assign bf_en      = di_en & (state_q == RUN) & in_cnt_q[LD];
  assign do_en      = fl_act_q | run_out;
  assign tw_en      = do_en & out_cnt_q[LD];
  assign tw_addr    = tw_en
                    ? ((out_cnt_q & LN'(DEPTH - 1)) << SH)
                    : '0;
  assign frame_done = do_en & (out_cnt_q == LN'(N - 1));

`ifdef FFT_STAGE_CTRL_GAP_CHECK_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      fl_cnt_q  <= '0;
      fl_act_q  <= 1'b0;
`ifdef FFT_STAGE_CTRL_GAP_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      if (do_en) out_cnt_q <= out_cnt_q + LN'(1);
      if (fl_act_q) begin
        if (fl_last) begin
          fl_act_q <= 1'b0;
          fl_cnt_q <= '0;
        end else begin
          fl_cnt_q <= fl_cnt_q + FW'(1);
        end
      end
      unique case (state_q)
        IDLE: begin
          if (di_en) begin
            state_q  <= RUN;
            in_cnt_q <= LN'(1);
          end
        end
        RUN: begin
          if (di_en) begin
            if (in_last) begin
              state_q  <= FLUSH;
              in_cnt_q <= '0;
              fl_act_q <= 1'b1;
              fl_cnt_q <= '0;
            end else begin
              in_cnt_q <= in_cnt_q + LN'(1);
            end
          end
`ifdef FFT_STAGE_CTRL_GAP_CHECK_EN
          else begin
            err_q     <= 1'b1;
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            fl_cnt_q  <= '0;
            fl_act_q  <= 1'b0;
          end
`endif
        end
        FLUSH: begin
          if (di_en) begin
            state_q  <= RUN;
            in_cnt_q <= LN'(1);
          end else if (fl_last) begin
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
